// File: rtl/dmem_pkg.sv
// Shared encodings for the LSU-to-data-SRAM adapter.
package dmem_pkg;

  // Access size encoding on req_size
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  // Default byte base of the data window
  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store mask/replication and load extract/extend.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_wmask,
  output logic [31:0] o_st_din,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_dout,
  output logic [31:0] o_ld_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_ld_dout[{i_ld_addr_lo, 3'b000} +: 8];
  assign w_half = i_ld_addr_lo[1] ? i_ld_dout[31:16] : i_ld_dout[15:0];

  // Store path: select lanes and replicate data so any lane sees the right bytes
  always_comb begin
    o_st_wmask = 4'b0000;
    o_st_din   = 32'h0;
    case (i_st_size)
      SZ_BYTE: begin
        o_st_wmask = 4'b0001 << i_st_addr_lo;
        o_st_din   = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_st_wmask = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_st_din   = {2{i_st_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_st_wmask = 4'b1111;
        o_st_din   = i_st_wdata;
      end
      default: ;
    endcase
  end

  // Load path: pull the addressed lane down and sign/zero-extend it
  always_comb begin
    o_ld_rdata = 32'h0;
    case (i_ld_size)
      SZ_BYTE: o_ld_rdata = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_rdata = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      SZ_WORD: o_ld_rdata = i_ld_dout;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_adapter.sv
// LSU request/response bridge onto port 0 of the 32x256 data SRAM.
// All SRAM pins are registered; one transaction in flight at a time.
module dmem_lsu_adapter
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_WMASKS = 4,
  parameter logic [31:0] BASE_ADDR  = DMEM_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_sram_csb,
  output logic                  o_sram_web,
  output logic [NUM_WMASKS-1:0] o_sram_wmask,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [31:0]           o_sram_din,
  input  logic [31:0]           i_sram_dout
);

  // One past the last legal byte; 33 bits so the top of memory cannot wrap
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

  dmem_state_e r_state, w_state_nxt;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [1:0]            r_addr_lo;
  logic                  r_rsp_err;
  logic [31:0]           r_rsp_rdata;
  logic                  r_sram_csb;
  logic                  r_sram_web;
  logic [NUM_WMASKS-1:0] r_sram_wmask;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [31:0]           r_sram_din;

  logic        w_acc;
  logic        w_err;
  logic        w_in_win;
  logic [3:0]  w_st_wmask;
  logic [31:0] w_st_din;
  logic [31:0] w_ld_rdata;

  assign w_acc    = (r_state == ST_IDLE) && i_req_valid;
  assign w_in_win = (i_req_addr >= BASE_ADDR) && ({1'b0, i_req_addr} < WIN_END);

  // Classify the incoming request: illegal size, misalignment or outside window
  always_comb begin
    w_err = ~w_in_win;
    case (i_req_size)
      SZ_HALF: if (i_req_addr[0])          w_err = 1'b1;
      SZ_WORD: if (i_req_addr[1:0] != 2'b00) w_err = 1'b1;
      SZ_ILL:  w_err = 1'b1;
      default: ;
    endcase
  end

  // Store lanes are formatted from live request inputs (loaded into pin flops at
  // acceptance); load lanes use the latched request against SRAM read data.
  dmem_lane_fmt u_fmt (
    .i_st_size     (i_req_size),
    .i_st_addr_lo  (i_req_addr[1:0]),
    .i_st_wdata    (i_req_wdata),
    .o_st_wmask    (w_st_wmask),
    .o_st_din      (w_st_din),
    .i_ld_size     (r_size),
    .i_ld_addr_lo  (r_addr_lo),
    .i_ld_unsigned (r_uns),
    .i_ld_dout     (i_sram_dout),
    .o_ld_rdata    (w_ld_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: errors skip straight to the response
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_req_valid) w_state_nxt = w_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_WAIT;
      ST_WAIT:   w_state_nxt = ST_RESP;
      ST_RESP:   if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals decoded from state
  always_comb begin
    o_req_ready = (r_state == ST_IDLE);
    o_rsp_valid = (r_state == ST_RESP);
  end

  // Latch request attributes needed after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_size    <= SZ_BYTE;
      r_uns     <= 1'b0;
      r_addr_lo <= 2'b00;
    end else if (w_acc) begin
      r_we      <= i_req_we;
      r_size    <= i_req_size;
      r_uns     <= i_req_unsigned;
      r_addr_lo <= i_req_addr[1:0];
    end
  end

  // SRAM pin flops: drive one access cycle, then park deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sram_csb   <= 1'b1;
      r_sram_web   <= 1'b1;
      r_sram_wmask <= '0;
      r_sram_addr  <= '0;
      r_sram_din   <= 32'h0;
    end else if (w_acc && !w_err) begin
      r_sram_csb   <= 1'b0;
      r_sram_web   <= ~i_req_we;
      r_sram_wmask <= i_req_we ? w_st_wmask : '0;
      r_sram_addr  <= i_req_addr[ADDR_WIDTH+1:2];
      r_sram_din   <= w_st_din;
    end else if (r_state == ST_ACCESS) begin
      r_sram_csb   <= 1'b1;
      r_sram_web   <= 1'b1;
      r_sram_wmask <= '0;
    end
  end

  // Response registers: error set at acceptance, load data captured at end of WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else if (w_acc) begin
      r_rsp_err   <= w_err;
      r_rsp_rdata <= 32'h0;
    end else if (r_state == ST_WAIT) begin
      r_rsp_rdata <= r_we ? 32'h0 : w_ld_rdata;
    end
  end

  assign o_rsp_err    = r_rsp_err;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_sram_csb   = r_sram_csb;
  assign o_sram_web   = r_sram_web;
  assign o_sram_wmask = r_sram_wmask;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_din   = r_sram_din;

endmodule

// File: tb/tb_dmem_lsu_adapter.sv
// Directed bench for dmem_lsu_adapter with a cycle-accurate SRAM port model.
module tb_dmem_lsu_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_lsu_adapter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_sram_csb     (sram_csb),
    .o_sram_web     (sram_web),
    .o_sram_wmask   (sram_wmask),
    .o_sram_addr    (sram_addr),
    .o_sram_din     (sram_din),
    .i_sram_dout    (sram_dout)
  );

  // SRAM model: sample pins at posedge, write/read at the following negedge,
  // read data trashed again at the next posedge.
  logic [31:0] mem [256];
  logic        mem_clr;
  logic        s_csb = 1'b1, s_web = 1'b1;
  logic [3:0]  s_mask;
  logic [7:0]  s_addr;
  logic [31:0] s_din;
  int          n_acc = 0;
  logic        l_web;
  logic [3:0]  l_mask;
  logic [7:0]  l_addr;
  logic [31:0] l_din;

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      s_csb     <= sram_csb;
      s_web     <= sram_web;
      s_mask    <= sram_wmask;
      s_addr    <= sram_addr;
      s_din     <= sram_din;
      sram_dout <= 32'hA5A5_5A5A;
      if (!sram_csb) begin
        n_acc  <= n_acc + 1;
        l_web  <= sram_web;
        l_mask <= sram_wmask;
        l_addr <= sram_addr;
        l_din  <= sram_din;
      end
    end else begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[4] <= 32'h1122_3344;
      end else if (!s_csb) begin
        if (!s_web) begin
          for (int b = 0; b < 4; b++)
            if (s_mask[b]) mem[s_addr][8*b +: 8] <= s_din[8*b +: 8];
        end else begin
          sram_dout <= mem[s_addr];
        end
      end
    end
  end

  // Acceptance log for throughput checks
  int cyc = 0, acc_cnt = 0, acc_last = 0, acc_prev = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready && rst_n) begin
      acc_cnt  <= acc_cnt + 1;
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE, wait for its response and retire it.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, output logic [31:0] rd, output logic er);
    int lat;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = $urandom;
    req_size = 2'd3; req_we = ~we; req_unsigned = ~uns;
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  logic [1:0]  e_sz [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
  logic [31:0] e_a  [5] = '{32'h1001, 32'h1002, 32'h1000, 32'h0FFF, 32'h1400};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n0, a0, lat;
    logic        seen;

    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_csb", sram_csb, 1);
    chk("rst_web", sram_web, 1);
    chk("rst_wmask", sram_wmask, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_din", sram_din, 0);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(posedge clk); #1;

    // Word store then load
    n0 = n_acc;
    do_req("sw", 1, 2'd2, 0, 32'h1008, 32'hDEAD_BEEF, 2, rd, er);
    chk("sw_err", er, 0);
    chk("sw_rdata", rd, 0);
    chk("sw_nacc", n_acc - n0, 1);
    chk("sw_web", l_web, 0);
    chk("sw_mask", l_mask, 4'b1111);
    chk("sw_addr", l_addr, 2);
    chk("sw_din", l_din, 32'hDEAD_BEEF);
    do_req("lw", 0, 2'd2, 1, 32'h1008, 0, 2, rd, er);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_err", er, 0);
    chk("lw_web", l_web, 1);
    chk("lw_mask", l_mask, 0);

    // Byte store with junk upper bits, then loads
    do_req("sb", 1, 2'd0, 0, 32'h1013, 32'hABCD_EF80, 2, rd, er);
    chk("sb_mask", l_mask, 4'b1000);
    chk("sb_din", l_din, 32'h8080_8080);
    chk("sb_addr", l_addr, 4);
    do_req("lb", 0, 2'd0, 0, 32'h1013, 0, 2, rd, er);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    do_req("lbu", 0, 2'd0, 1, 32'h1013, 0, 2, rd, er);
    chk("lbu_rdata", rd, 32'h0000_0080);
    do_req("lw10", 0, 2'd2, 0, 32'h1010, 0, 2, rd, er);
    chk("lw10_rdata", rd, 32'h8022_3344);
    do_req("lb11", 0, 2'd0, 0, 32'h1011, 0, 2, rd, er);
    chk("lb11_rdata", rd, 32'h0000_0033);

    // Half stores and loads
    do_req("sh", 1, 2'd1, 0, 32'h1006, 32'hFFFF_1234, 2, rd, er);
    chk("sh_mask", l_mask, 4'b1100);
    chk("sh_din", l_din, 32'h1234_1234);
    chk("sh_addr", l_addr, 1);
    do_req("sh2", 1, 2'd1, 0, 32'h1006, 32'h0000_8001, 2, rd, er);
    do_req("lh", 0, 2'd1, 0, 32'h1006, 0, 2, rd, er);
    chk("lh_rdata", rd, 32'hFFFF_8001);
    do_req("lhu", 0, 2'd1, 1, 32'h1006, 0, 2, rd, er);
    chk("lhu_rdata", rd, 32'h0000_8001);
    do_req("lw4", 0, 2'd2, 0, 32'h1004, 0, 2, rd, er);
    chk("lw4_rdata", rd, 32'h8001_0000);
    do_req("sh4", 1, 2'd1, 0, 32'h1004, 32'h0000_7FFE, 2, rd, er);
    chk("sh4_mask", l_mask, 4'b0011);
    do_req("lh4", 0, 2'd1, 0, 32'h1004, 0, 2, rd, er);
    chk("lh4_rdata", rd, 32'h0000_7FFE);

    // Error requests never reach the SRAM
    for (int i = 0; i < 5; i++) begin
      n0 = n_acc;
      do_req($sformatf("err%0d", i), i[0], e_sz[i], 0, e_a[i], 32'h5555_5555, 0, rd, er);
      chk($sformatf("err%0d_err", i), er, 1);
      chk($sformatf("err%0d_rdata", i), rd, 0);
      chk($sformatf("err%0d_nacc", i), n_acc - n0, 0);
    end

    // Last byte of the window
    do_req("sbtop", 1, 2'd0, 0, 32'h13FF, 32'h0000_005A, 2, rd, er);
    chk("sbtop_err", er, 0);
    chk("sbtop_addr", l_addr, 255);
    chk("sbtop_mask", l_mask, 4'b1000);
    do_req("lbtop", 0, 2'd0, 0, 32'h13FF, 0, 2, rd, er);
    chk("lbtop_rdata", rd, 32'h0000_005A);

    // Backpressure with a competing request held on the input
    rsp_ready = 1'b0;
    req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h1008; req_valid = 1'b1;
    @(posedge clk); #1;
    n0 = n_acc;
    req_we = 1; req_addr = 32'h1010; req_wdata = 32'h0;
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", lat, 2);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_ready", req_ready, 0);
      chk("bp_csb", sram_csb, 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", rsp_valid, 0);
    chk("bp_rel_ready", req_ready, 1);
    chk("bp_nacc", n_acc - n0, 1);

    // Back-to-back acceptances with req_valid held high
    a0 = acc_cnt;
    req_we = 0; req_size = 2'd2; req_addr = 32'h1008; req_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("b2b_cnt", acc_cnt - a0, 3);
    chk("b2b_gap", acc_last - acc_prev, 4);
    chk("b2b_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("b2b_idle", req_ready, 1);

    // Asynchronous reset while the SRAM is selected
    req_we = 1; req_size = 2'd2; req_addr = 32'h1008; req_wdata = 32'h0BAD_F00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mr_csb_pre", sram_csb, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_csb", sram_csb, 1);
    chk("mr_rvalid", rsp_valid, 0);
    chk("mr_ready", req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("mr_stray", seen, 0);
    chk("mr_ready2", req_ready, 1);
    do_req("mr_lw", 0, 2'd2, 0, 32'h1008, 0, 2, rd, er);
    chk("mr_lw_rdata", rd, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
